// File: rtl/pc_pkg.sv
// Shared definitions for the WISC program-counter unit: state encoding,
// sequential step size and default reset address.
package pc_pkg;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } pc_state_e;

  localparam int unsigned PC_STEP = 2;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between decode/execute/fetch (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             rewind;
  logic             halt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus2;
  logic             fetch_valid;
  logic             halted;
  logic             align_err;

  modport master (
    output stall, redirect, redirect_pc, rewind, halt,
    input  pc, pc_plus2, fetch_valid, halted, align_err
  );

  modport slave (
    input  stall, redirect, redirect_pc, rewind, halt,
    output pc, pc_plus2, fetch_valid, halted, align_err
  );

endinterface

// File: rtl/pc_unit_add_sub_2.sv
// Combinational WIDTH-bit +/-2 unit: a ripple chain of full-adder cells whose
// second operand is +2, or its two's complement when sub_i is set.
module pc_unit_add_sub_2
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;

  assign step = WIDTH'(PC_STEP);
  assign b    = sub_i ? ~step : step;
  assign c[0] = sub_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign y_o[i] = a_i[i] ^ b[i] ^ c[i];
    // Carry out of the top bit is discarded so the result wraps mod 2^WIDTH.
    if (i < WIDTH - 1) begin : g_carry
      assign c[i+1] = (a_i[i] & b[i]) | (c[i] & (a_i[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Architectural program counter with increment, rewind, redirect, stall and halt.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  ctrl_io
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             align_err_q, align_err_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] plus2;

  // The same unit yields pc+2 or pc-2 depending on rewind.
  pc_unit_add_sub_2 #(.WIDTH(WIDTH)) u_seq (
    .a_i   (pc_q),
    .sub_i (ctrl_io.rewind),
    .y_o   (seq_pc)
  );

  pc_unit_add_sub_2 #(.WIDTH(WIDTH)) u_plus2 (
    .a_i   (pc_q),
    .sub_i (1'b0),
    .y_o   (plus2)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    align_err_d = align_err_q;
    if (state_q == StRun) begin
      if (ctrl_io.halt) begin
        state_d = StHalted;
      end else if (ctrl_io.redirect) begin
        pc_d        = {ctrl_io.redirect_pc[WIDTH-1:1], 1'b0};
        align_err_d = align_err_q | ctrl_io.redirect_pc[0];
      end else if (ctrl_io.rewind || !ctrl_io.stall) begin
        pc_d = seq_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  assign ctrl_io.pc          = pc_q;
  assign ctrl_io.pc_plus2    = plus2;
  assign ctrl_io.halted      = (state_q == StHalted);
  assign ctrl_io.align_err   = align_err_q;
  assign ctrl_io.fetch_valid = (state_q == StRun) && !ctrl_io.stall && !ctrl_io.halt;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, halted/reset sequences, and a
// randomized run against a behavioural PC model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        rewind;
  logic        halt;

  int n_pass = 0;
  int n_chk  = 0;

  logic [15:0] m_pc;
  logic        m_h;
  logic        m_a;

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(16)) if_a ();
  pc_unit_if #(.WIDTH(16)) if_b ();

  assign if_a.stall       = stall;
  assign if_a.redirect    = redirect;
  assign if_a.redirect_pc = redirect_pc;
  assign if_a.rewind      = rewind;
  assign if_a.halt        = halt;
  assign if_b.stall       = stall;
  assign if_b.redirect    = redirect;
  assign if_b.redirect_pc = redirect_pc;
  assign if_b.rewind      = rewind;
  assign if_b.halt        = halt;

  pc_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (if_a)
  );

  pc_unit #(.WIDTH(16), .RESET_PC(16'h0100)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (if_b)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        rw;
    logic        hl;
    logic        fv;
    logic [15:0] pc;
    logic        h;
    logic        a;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, st, rd, input logic [15:0] rpc,
                              input logic rw, hl, fv, input logic [15:0] pc,
                              input logic h, a);
    vec_t v;
    v.rst = r; v.st = st; v.rd = rd; v.rpc = rpc; v.rw = rw; v.hl = hl;
    v.fv = fv; v.pc = pc; v.h = h; v.a = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic r, st, rd, input logic [15:0] rpc, input logic rw, hl);
    rst = r; stall = st; redirect = rd; redirect_pc = rpc; rewind = rw; halt = hl;
  endtask

  // Advance one clock, updating the reference model from the applied inputs.
  task automatic tick();
    if (rst) begin
      m_pc = 16'h0000; m_h = 1'b0; m_a = 1'b0;
    end else if (!m_h) begin
      if (halt) m_h = 1'b1;
      else if (redirect) begin
        m_pc = redirect_pc & 16'hFFFE;
        if (redirect_pc[0]) m_a = 1'b1;
      end else if (rewind) m_pc = m_pc - 16'd2;
      else if (!stall) m_pc = m_pc + 16'd2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    logic [15:0] e2;
    e2 = m_pc + 16'd2;
    chk({tag, "_pc"}, 32'(if_a.pc), 32'(m_pc));
    chk({tag, "_pc_plus2"}, 32'(if_a.pc_plus2), 32'(e2));
    chk({tag, "_halted"}, 32'(if_a.halted), 32'(m_h));
    chk({tag, "_align_err"}, 32'(if_a.align_err), 32'(m_a));
  endtask

  initial begin
    logic [15:0] e2;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    m_pc = 16'h0; m_h = 1'b0; m_a = 1'b0;

    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0002, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0004, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0006, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'hFFFC, 0, 0, 1, 16'hFFFC, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'hFFFE, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0002, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 16'hFFFE, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0010, 0, 0, 1, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 16'h0123, 0, 0, 0, 16'h0122, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'h0040, 0, 0, 1, 16'h0040, 0, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h003E, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'h0200, 1, 0, 1, 16'h0200, 0, 1));
    tbl.push_back(mk(0, 0, 1, 16'h0086, 0, 0, 1, 16'h0086, 0, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0086, 1, 1));

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rw, tbl[i].hl);
      #1;
      if (!tbl[i].rst) chk($sformatf("tbl%0d_fetch_valid", i), 32'(if_a.fetch_valid),
                           32'(tbl[i].fv));
      tick();
      e2 = tbl[i].pc + 16'd2;
      chk($sformatf("tbl%0d_pc", i), 32'(if_a.pc), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_pc_plus2", i), 32'(if_a.pc_plus2), 32'(e2));
      chk($sformatf("tbl%0d_halted", i), 32'(if_a.halted), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_align_err", i), 32'(if_a.align_err), 32'(tbl[i].a));
    end

    // Halted: controls are ignored for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      #1;
      chk("halted_fetch_valid", 32'(if_a.fetch_valid), 32'h0);
      tick();
      chk("halted_pc", 32'(if_a.pc), 32'h0086);
      chk("halted_flag", 32'(if_a.halted), 32'h1);
      chk("halted_align_err", 32'(if_a.align_err), 32'h1);
    end

    // Reset out of HALTED with align_err set.
    drive(1'b1, 1'b1, 1'b1, 16'h0333, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("rst_halted_pc", 32'(if_a.pc), 32'h0000);
    chk("rst_halted_flag", 32'(if_a.halted), 32'h0);
    chk("rst_halted_align", 32'(if_a.align_err), 32'h0);
    chk("rst_halted_fv", 32'(if_a.fetch_valid), 32'h1);
    chk("rst_b_pc", 32'(if_b.pc), 32'h0100);

    // Reset mid-run at 0x1234, controls undriven during reset.
    drive(1'b0, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0);
    tick();
    chk("run_pc_1234", 32'(if_a.pc), 32'h1234);
    chk("run_align_set", 32'(if_a.align_err), 32'h1);
    rst = 1'b1; stall = 1'bx; redirect = 1'bx; redirect_pc = 16'hxxxx;
    rewind = 1'bx; halt = 1'bx;
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("rst_run_pc", 32'(if_a.pc), 32'h0000);
    chk("rst_run_align", 32'(if_a.align_err), 32'h0);
    chk("rst_run_halted", 32'(if_a.halted), 32'h0);
    chk("rst_run_fv", 32'(if_a.fetch_valid), 32'h1);
    chk("rst_run_b_pc", 32'(if_b.pc), 32'h0100);
    tick();
    chk("post_rst_pc", 32'(if_a.pc), 32'h0002);
    chk("post_rst_b_pc", 32'(if_b.pc), 32'h0102);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 30),
            1'($urandom_range(0, 99) < 20), 16'($urandom),
            1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 3));
      #1;
      chk("rnd_fetch_valid", 32'(if_a.fetch_valid), 32'(!m_h && !stall && !halt));
      tick();
      chk_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
